// File: rtl/dma_pkg.sv
// ----------------------------------------------------------------------------
// dma_pkg
// Types and widths shared by the DMA read engine and its output FIFO.
//   dma_state_t : engine control state (IDLE -> ISSUE -> DRAIN -> DONE)
//   DONE_CNT_W  : width of the completed-buffer counter
//   BURSTCNT_W  : width of the Avalon-MM burstcount field
// ----------------------------------------------------------------------------
package dma_pkg;

    localparam int DONE_CNT_W = 16;
    localparam int BURSTCNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_t;

endpackage

// File: rtl/dma_rd_fifo.sv
// ----------------------------------------------------------------------------
// dma_rd_fifo
// Synchronous show-ahead FIFO. The head entry is always visible on o_rd_data
// while o_empty is low; i_rd_en pops it. A write and a read in the same cycle
// leave the occupancy unchanged, and a write is accepted when full only if a
// read happens in the same cycle.
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset (clears pointers/count)
//   i_wr_en     : push i_wr_data
//   i_wr_data   : data to push
//   i_rd_en     : pop the head entry (ignored when empty)
//   o_rd_data   : head entry
//   o_empty     : no entries stored
//   o_count     : number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module dma_rd_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 128
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_rd      = i_rd_en & ~o_empty;
    assign w_wr      = i_wr_en & (~w_full | w_rd);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array has no reset; only the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dma_read_engine.sv
// ----------------------------------------------------------------------------
// dma_read_engine
// Reads a buffer of BUF_SIZE words starting at START_ADR from SDRAM through an
// Avalon-MM burst read master and streams the words out in order through a
// show-ahead FIFO. A burst is only requested when the FIFO is guaranteed to
// have space for every beat already in flight plus the new burst, so the
// FIFO never overflows even if the stream consumer stalls.
//
// Optional feature (compile-time macro DMA_RD_SWAP16_EN):
//   defined   : OUT_DATA swaps the 16-bit halves inside every 32-bit lane
//   undefined : OUT_DATA carries SDRAM_READDATA unmodified
//
// Ports:
//   CLK, RST_N              : clock, asynchronous active-low reset
//   START                   : one-cycle command strobe (accepted in IDLE only)
//   START_ADR, BUF_SIZE     : buffer start / length in DATA_W-word units
//   BUSY                    : command in progress
//   DONE_CNT                : completed-buffer counter (wraps)
//   CMD_DROP                : one-cycle pulse when a START was ignored
//   SDRAM_*                 : Avalon-MM burst read master
//   OUT_DATA/VALID/READY    : output stream, transfer on VALID & READY
// ----------------------------------------------------------------------------
module dma_read_engine
    import dma_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int ADR_W      = 28,
    parameter int BURST_MAX  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [ADR_W-1:0]      START_ADR,
    input  logic [ADR_W-1:0]      BUF_SIZE,
    output logic                  BUSY,
    output logic [DONE_CNT_W-1:0] DONE_CNT,
    output logic                  CMD_DROP,
    output logic [ADR_W-1:0]      SDRAM_ADDRESS,
    output logic [BURSTCNT_W-1:0] SDRAM_BURSTCOUNT,
    output logic                  SDRAM_READ,
    input  logic                  SDRAM_WAITREQUEST,
    input  logic [DATA_W-1:0]     SDRAM_READDATA,
    input  logic                  SDRAM_READDATAVALID,
    output logic [DATA_W-1:0]     OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    dma_state_t            r_state;
    logic [ADR_W-1:0]      r_addr;
    logic [ADR_W-1:0]      r_remaining;
    logic [BURSTCNT_W-1:0] r_burst;
    logic                  r_read;
    logic [OCC_W-1:0]      r_outstanding;
    logic                  r_cmd_drop;
    logic [DONE_CNT_W-1:0] r_done_cnt;
    logic                  r_accept_beats;

    logic                  w_accepted;
    logic                  w_beat_wr;
    logic                  w_fifo_rd;
    logic                  w_fifo_empty;
    logic [OCC_W-1:0]      w_fifo_count;
    logic [DATA_W-1:0]     w_fifo_rdata;
    logic [BURSTCNT_W-1:0] w_burst_len;
    logic [31:0]           w_need;
    logic                  w_room_ok;
    logic [ADR_W-1:0]      w_remaining_after;
    logic [OCC_W-1:0]      w_outstanding_nxt;
    logic [DONE_CNT_W-1:0] w_done_cnt_nxt;

    assign w_accepted = r_read & ~SDRAM_WAITREQUEST;

    // Beats that belong to a command cut short by reset may still trickle in;
    // they are discarded until a fresh command is accepted.
    assign w_beat_wr = SDRAM_READDATAVALID & r_accept_beats;
    assign w_fifo_rd = OUT_VALID & OUT_READY;

    assign w_burst_len = (r_remaining >= ADR_W'(BURST_MAX)) ?
                         BURSTCNT_W'(BURST_MAX) : r_remaining[BURSTCNT_W-1:0];

    // Space check: every beat in flight plus everything stored plus the new
    // burst must fit. A beat moving from in-flight into the FIFO keeps the
    // sum constant, so the check stays valid while a request waits.
    assign w_need    = 32'(r_outstanding) + 32'(w_fifo_count) + 32'(w_burst_len);
    assign w_room_ok = (w_need <= 32'(FIFO_DEPTH));

    assign w_remaining_after = r_remaining - ADR_W'(r_burst);

    assign w_done_cnt_nxt = (r_state == ST_DONE) ? r_done_cnt + 1'b1 : r_done_cnt;

    // In-flight beat counter: grows by the burst length on acceptance and
    // shrinks by one for every returned beat; both can happen in one cycle.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_accepted) begin
            w_outstanding_nxt = w_outstanding_nxt + OCC_W'(r_burst);
        end
        if (w_beat_wr && (r_outstanding != '0)) begin
            w_outstanding_nxt = w_outstanding_nxt - 1'b1;
        end
    end

    // Command FSM and Avalon request generation. The request registers are
    // only changed when no request is pending or the pending one is accepted,
    // which keeps them stable across waitrequest.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_burst        <= '0;
            r_read         <= 1'b0;
            r_outstanding  <= '0;
            r_cmd_drop     <= 1'b0;
            r_done_cnt     <= '0;
            r_accept_beats <= 1'b0;
        end else begin
            r_cmd_drop    <= START & (r_state != ST_IDLE);
            r_outstanding <= w_outstanding_nxt;
            r_done_cnt    <= w_done_cnt_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_addr         <= START_ADR;
                        r_remaining    <= BUF_SIZE;
                        r_accept_beats <= 1'b1;
                        if (BUF_SIZE == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_read) begin
                        if (!SDRAM_WAITREQUEST) begin
                            r_read      <= 1'b0;
                            r_addr      <= r_addr + ADR_W'(r_burst);
                            r_remaining <= w_remaining_after;
                            if (w_remaining_after == '0) begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end else if (w_room_ok) begin
                        r_read  <= 1'b1;
                        r_burst <= w_burst_len;
                    end
                end
                ST_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    dma_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_wr_en   (w_beat_wr),
        .i_wr_data (SDRAM_READDATA),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (w_fifo_rdata),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

`ifdef DMA_RD_SWAP16_EN
    // Swap 16-bit halves inside each 32-bit lane.
    for (genvar g = 0; g < DATA_W / 32; g++) begin : g_swap
        assign OUT_DATA[32*g +: 32] = {w_fifo_rdata[32*g +: 16], w_fifo_rdata[32*g+16 +: 16]};
    end
`else
    assign OUT_DATA = w_fifo_rdata;
`endif

    assign OUT_VALID        = ~w_fifo_empty;
    assign BUSY             = (r_state != ST_IDLE);
    assign DONE_CNT         = r_done_cnt;
    assign CMD_DROP         = r_cmd_drop;
    assign SDRAM_ADDRESS    = r_addr;
    assign SDRAM_BURSTCOUNT = r_burst;
    assign SDRAM_READ       = r_read;

endmodule

// File: tb/tb_dma_read_engine.sv
// ----------------------------------------------------------------------------
// tb_dma_read_engine
// Directed bench for dma_read_engine: an SDRAM responder model returns beats
// whose data encodes their word address, and an output sink compares every
// streamed word against the address sequence the bench expects.
// ----------------------------------------------------------------------------
module tb_dma_read_engine;

    localparam int DATA_W     = 128;
    localparam int ADR_W      = 28;
    localparam int BURST_MAX  = 16;
    localparam int FIFO_DEPTH = 64;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              START = 1'b0;
    logic [ADR_W-1:0]  START_ADR = '0;
    logic [ADR_W-1:0]  BUF_SIZE = '0;
    logic              BUSY;
    logic [15:0]       DONE_CNT;
    logic              CMD_DROP;
    logic [ADR_W-1:0]  SDRAM_ADDRESS;
    logic [7:0]        SDRAM_BURSTCOUNT;
    logic              SDRAM_READ;
    logic              sdWait = 1'b0;
    logic [DATA_W-1:0] sdData = '0;
    logic              sdRdv = 1'b0;
    logic [DATA_W-1:0] OUT_DATA;
    logic              OUT_VALID;
    logic              OUT_READY = 1'b1;

    int checkCnt = 0;
    int passCnt  = 0;

    // Responder / sink state
    logic [ADR_W-1:0] beatQ[$];
    logic [ADR_W-1:0] expQ[$];
    logic [ADR_W-1:0] burstAdr[$];
    logic [7:0]       burstLen[$];
    logic [ADR_W-1:0] refAdr;
    logic [7:0]       refLen;
    logic [ADR_W-1:0] expAdr;
    bit               inReq = 0;
    bit               randWait = 0;
    bit               rdvHold = 0;
    int               waitLeft = 0;
    int               stabErrs = 0;
    int               readSeen = 0;
    int               acceptedBeats = 0;
    int               outCnt = 0;
    int               outErrs = 0;

    dma_read_engine #(
        .DATA_W     (DATA_W),
        .ADR_W      (ADR_W),
        .BURST_MAX  (BURST_MAX),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK                 (CLK),
        .RST_N               (RST_N),
        .START               (START),
        .START_ADR           (START_ADR),
        .BUF_SIZE            (BUF_SIZE),
        .BUSY                (BUSY),
        .DONE_CNT            (DONE_CNT),
        .CMD_DROP            (CMD_DROP),
        .SDRAM_ADDRESS       (SDRAM_ADDRESS),
        .SDRAM_BURSTCOUNT    (SDRAM_BURSTCOUNT),
        .SDRAM_READ          (SDRAM_READ),
        .SDRAM_WAITREQUEST   (sdWait),
        .SDRAM_READDATA      (sdData),
        .SDRAM_READDATAVALID (sdRdv),
        .OUT_DATA            (OUT_DATA),
        .OUT_VALID           (OUT_VALID),
        .OUT_READY           (OUT_READY)
    );

    always #5 CLK = ~CLK;

    // Data the SDRAM model returns for a given word address.
    function automatic logic [DATA_W-1:0] beatData(input logic [ADR_W-1:0] a);
        logic [31:0] w;
        w = 32'hA500_0000 ^ {4'h0, a};
        return {w ^ 32'h0003_0000, w ^ 32'h0002_0000, w ^ 32'h0001_0000, w};
    endfunction

    // Word expected on OUT_DATA for a given word address.
    function automatic logic [DATA_W-1:0] expData(input logic [ADR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = beatData(a);
`ifdef DMA_RD_SWAP16_EN
        for (int l = 0; l < DATA_W / 32; l++) begin
            d[32*l +: 32] = {d[32*l +: 16], d[32*l+16 +: 16]};
        end
`endif
        return d;
    endfunction

    // SDRAM model: decides waitrequest and returns beats at the falling edge
    // so everything is stable for the DUT's rising edge.
    always @(negedge CLK) begin
        if (!RST_N) begin
            sdWait = 1'b0;
            sdRdv  = 1'b0;
            inReq  = 0;
        end else begin
            if (!rdvHold && beatQ.size() > 0) begin
                sdRdv  = 1'b1;
                sdData = beatData(beatQ.pop_front());
            end else begin
                sdRdv = 1'b0;
            end
            if (SDRAM_READ) begin
                if (!inReq) begin
                    inReq    = 1;
                    refAdr   = SDRAM_ADDRESS;
                    refLen   = SDRAM_BURSTCOUNT;
                    waitLeft = randWait ? int'($urandom_range(150, 10)) : 0;
                    readSeen++;
                end else if (SDRAM_ADDRESS !== refAdr || SDRAM_BURSTCOUNT !== refLen) begin
                    stabErrs++;
                end
                if (waitLeft > 0) begin
                    sdWait = 1'b1;
                    waitLeft--;
                end else begin
                    sdWait = 1'b0;
                    inReq  = 0;
                    burstAdr.push_back(refAdr);
                    burstLen.push_back(refLen);
                    for (int i = 0; i < int'(refLen); i++) begin
                        beatQ.push_back(refAdr + ADR_W'(i));
                    end
                    acceptedBeats += int'(refLen);
                end
            end else begin
                sdWait = 1'b0;
            end
        end
    end

    // Output sink: a word seen with VALID & READY at the falling edge is
    // transferred on the next rising edge.
    always @(negedge CLK) begin
        if (RST_N && OUT_VALID && OUT_READY) begin
            outCnt++;
            if (expQ.size() == 0) begin
                outErrs++;
            end else begin
                expAdr = expQ.pop_front();
                if (OUT_DATA !== expData(expAdr)) begin
                    outErrs++;
                end
            end
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        checkCnt++;
        assert (observed === expected) begin
            passCnt++;
        end else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Queue the expected output words and strobe START for one cycle.
    task automatic applyStimulus(input logic [ADR_W-1:0] adr, input logic [ADR_W-1:0] size);
        for (int i = 0; i < int'(size); i++) begin
            expQ.push_back(adr + ADR_W'(i));
        end
        tick(1);
        START     = 1'b1;
        START_ADR = adr;
        BUF_SIZE  = size;
        tick(1);
        START = 1'b0;
    endtask

    // Wait (bounded) until the command completes and the FIFO has drained.
    task automatic waitIdle(input int maxCyc, input string tag);
        int n;
        n = 0;
        while ((BUSY !== 1'b0 || OUT_VALID !== 1'b0) && n < maxCyc) begin
            tick(1);
            n++;
        end
        tick(2);
        checkOutput({tag, "_idle"}, DATA_W'(BUSY), DATA_W'(1'b0));
    endtask

    task automatic clearLogs();
        burstAdr.delete();
        burstLen.delete();
        outCnt        = 0;
        outErrs       = 0;
        stabErrs      = 0;
        acceptedBeats = 0;
    endtask

    initial begin
        // Reset values
        tick(3);
        checkOutput("rst_busy",   DATA_W'(BUSY),             DATA_W'(1'b0));
        checkOutput("rst_read",   DATA_W'(SDRAM_READ),       DATA_W'(1'b0));
        checkOutput("rst_addr",   DATA_W'(SDRAM_ADDRESS),    DATA_W'(0));
        checkOutput("rst_bcnt",   DATA_W'(SDRAM_BURSTCOUNT), DATA_W'(0));
        checkOutput("rst_done",   DATA_W'(DONE_CNT),         DATA_W'(0));
        checkOutput("rst_drop",   DATA_W'(CMD_DROP),         DATA_W'(1'b0));
        checkOutput("rst_ovalid", DATA_W'(OUT_VALID),        DATA_W'(1'b0));
        RST_N = 1'b1;
        tick(2);

        // Basic 40-word buffer, no waitrequest
        $display("[TB] basic transfer");
        clearLogs();
        applyStimulus(28'h100, 28'd40);
        waitIdle(2000, "t1");
        checkOutput("t1_nbursts", DATA_W'(burstAdr.size()), DATA_W'(3));
        checkOutput("t1_adr0",    DATA_W'(burstAdr[0]), DATA_W'(28'h100));
        checkOutput("t1_len0",    DATA_W'(burstLen[0]), DATA_W'(16));
        checkOutput("t1_adr1",    DATA_W'(burstAdr[1]), DATA_W'(28'h110));
        checkOutput("t1_len1",    DATA_W'(burstLen[1]), DATA_W'(16));
        checkOutput("t1_adr2",    DATA_W'(burstAdr[2]), DATA_W'(28'h120));
        checkOutput("t1_len2",    DATA_W'(burstLen[2]), DATA_W'(8));
        checkOutput("t1_outcnt",  DATA_W'(outCnt),  DATA_W'(40));
        checkOutput("t1_outerr",  DATA_W'(outErrs), DATA_W'(0));
        checkOutput("t1_done",    DATA_W'(DONE_CNT), DATA_W'(1));

        // Random waitrequest, buffer crossing the top of the address space
        $display("[TB] random waitrequest with address wrap");
        clearLogs();
        randWait = 1;
        applyStimulus(28'hFFF_FFF8, 28'd40);
        waitIdle(5000, "t2");
        randWait = 0;
        checkOutput("t2_stable",  DATA_W'(stabErrs), DATA_W'(0));
        checkOutput("t2_nbursts", DATA_W'(burstAdr.size()), DATA_W'(3));
        checkOutput("t2_adr1",    DATA_W'(burstAdr[1]), DATA_W'(28'h000_0008));
        checkOutput("t2_adr2",    DATA_W'(burstAdr[2]), DATA_W'(28'h000_0018));
        checkOutput("t2_len2",    DATA_W'(burstLen[2]), DATA_W'(8));
        checkOutput("t2_outcnt",  DATA_W'(outCnt),  DATA_W'(40));
        checkOutput("t2_outerr",  DATA_W'(outErrs), DATA_W'(0));
        checkOutput("t2_done",    DATA_W'(DONE_CNT), DATA_W'(2));

        // Consumer stalled: requests must stop at FIFO_DEPTH beats
        $display("[TB] backpressure");
        clearLogs();
        OUT_READY = 1'b0;
        applyStimulus(28'h1000, 28'd200);
        tick(300);
        checkOutput("t3_stall_beats", DATA_W'(acceptedBeats), DATA_W'(64));
        checkOutput("t3_stall_read",  DATA_W'(SDRAM_READ), DATA_W'(1'b0));
        checkOutput("t3_stall_valid", DATA_W'(OUT_VALID),  DATA_W'(1'b1));
        checkOutput("t3_stall_busy",  DATA_W'(BUSY),       DATA_W'(1'b1));
        OUT_READY = 1'b1;
        waitIdle(5000, "t3");
        checkOutput("t3_beats",  DATA_W'(acceptedBeats), DATA_W'(200));
        checkOutput("t3_outcnt", DATA_W'(outCnt),  DATA_W'(200));
        checkOutput("t3_outerr", DATA_W'(outErrs), DATA_W'(0));
        checkOutput("t3_done",   DATA_W'(DONE_CNT), DATA_W'(3));

        // START while busy is dropped
        $display("[TB] command drop");
        clearLogs();
        for (int i = 0; i < 20; i++) begin
            expQ.push_back(28'h200 + ADR_W'(i));
        end
        tick(1);
        START     = 1'b1;
        START_ADR = 28'h200;
        BUF_SIZE  = 28'd20;
        tick(1);
        START_ADR = 28'h999;
        BUF_SIZE  = 28'd7;
        checkOutput("t4_drop_pre", DATA_W'(CMD_DROP), DATA_W'(1'b0));
        tick(1);
        START = 1'b0;
        checkOutput("t4_drop_pulse", DATA_W'(CMD_DROP), DATA_W'(1'b1));
        tick(1);
        checkOutput("t4_drop_end", DATA_W'(CMD_DROP), DATA_W'(1'b0));
        waitIdle(2000, "t4");
        checkOutput("t4_outcnt", DATA_W'(outCnt),  DATA_W'(20));
        checkOutput("t4_outerr", DATA_W'(outErrs), DATA_W'(0));
        checkOutput("t4_done",   DATA_W'(DONE_CNT), DATA_W'(4));

        // Reset mid-DRAIN with 5 beats still in flight
        $display("[TB] reset during drain");
        clearLogs();
        rdvHold = 1;
        tick(1);
        START     = 1'b1;
        START_ADR = 28'h300;
        BUF_SIZE  = 28'd5;
        tick(1);
        START = 1'b0;
        for (int n = 0; n < 100 && acceptedBeats < 5; n++) begin
            tick(1);
        end
        tick(2);
        checkOutput("t6_pre_busy", DATA_W'(BUSY), DATA_W'(1'b1));
        RST_N = 1'b0;
        #1;
        checkOutput("t6_busy",   DATA_W'(BUSY),             DATA_W'(1'b0));
        checkOutput("t6_read",   DATA_W'(SDRAM_READ),       DATA_W'(1'b0));
        checkOutput("t6_addr",   DATA_W'(SDRAM_ADDRESS),    DATA_W'(0));
        checkOutput("t6_bcnt",   DATA_W'(SDRAM_BURSTCOUNT), DATA_W'(0));
        checkOutput("t6_done",   DATA_W'(DONE_CNT),         DATA_W'(0));
        checkOutput("t6_drop",   DATA_W'(CMD_DROP),         DATA_W'(1'b0));
        checkOutput("t6_ovalid", DATA_W'(OUT_VALID),        DATA_W'(1'b0));
        tick(2);
        RST_N   = 1'b1;
        rdvHold = 0;
        tick(20);
        checkOutput("t6_late_beats", DATA_W'(outCnt),    DATA_W'(0));
        checkOutput("t6_late_valid", DATA_W'(OUT_VALID), DATA_W'(1'b0));
        checkOutput("t6_late_busy",  DATA_W'(BUSY),      DATA_W'(1'b0));

        // Zero-length buffer and DONE_CNT wrap
        $display("[TB] zero length and counter wrap");
        readSeen = 0;
        tick(1);
        START     = 1'b1;
        START_ADR = 28'h400;
        BUF_SIZE  = 28'd0;
        tick(1);
        START = 1'b0;
        checkOutput("t5_busy_done", DATA_W'(BUSY),     DATA_W'(1'b1));
        checkOutput("t5_cnt_hold",  DATA_W'(DONE_CNT), DATA_W'(0));
        tick(1);
        checkOutput("t5_cnt_inc",   DATA_W'(DONE_CNT), DATA_W'(1));
        checkOutput("t5_busy_idle", DATA_W'(BUSY),     DATA_W'(1'b0));
        force dut.w_done_cnt_nxt = 16'hFFFF;
        tick(1);
        release dut.w_done_cnt_nxt;
        checkOutput("t5_preset", DATA_W'(DONE_CNT), DATA_W'(16'hFFFF));
        tick(1);
        START    = 1'b1;
        BUF_SIZE = 28'd0;
        tick(1);
        START = 1'b0;
        tick(1);
        checkOutput("t5_wrap",  DATA_W'(DONE_CNT), DATA_W'(0));
        checkOutput("t5_noread", DATA_W'(readSeen), DATA_W'(0));

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/dma_read_engine.md
DMA_READ_ENGINE -- requirements
Module: dma_read_engine

Interface
REQ-001 SHALL have parameter DATA_W, 128, SDRAM data width in bits.
REQ-002 SHALL have parameter ADR_W, 28, SDRAM word-address width.
REQ-003 SHALL have parameter BURST_MAX, 16, max Avalon burstcount (power of 2, 1..128).
REQ-004 SHALL have parameter FIFO_DEPTH, 64, output FIFO depth in DATA_W words (power of 2, >= 2*BURST_MAX).
REQ-005 SHALL have port CLK  in  1  single clock for all logic.
REQ-006 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port START  in  1  one-cycle command strobe.
REQ-008 SHALL have port START_ADR  in  ADR_W  buffer start, 128-bit-word units.
REQ-009 SHALL have port BUF_SIZE  in  ADR_W  buffer length, 128-bit-word units.
REQ-010 SHALL have port BUSY  out  1  command in progress.
REQ-011 SHALL have port DONE_CNT  out  16  completed-buffer counter.
REQ-012 SHALL have port CMD_DROP  out  1  one-cycle pulse, START ignored.
REQ-013 SHALL have ports SDRAM_ADDRESS out ADR_W, SDRAM_BURSTCOUNT out 8, SDRAM_READ out 1, SDRAM_WAITREQUEST in 1, SDRAM_READDATA in DATA_W, SDRAM_READDATAVALID in 1 (Avalon-MM burst read master).
REQ-014 SHALL have ports OUT_DATA out DATA_W, OUT_VALID out 1, OUT_READY in 1 (stream, transfer when VALID&READY).

Function
REQ-015 SHALL use FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-016 SHALL in IDLE latch START_ADR/BUF_SIZE on START, enter ISSUE next cycle; BUF_SIZE=0 goes directly to DONE with no reads.
REQ-017 SHALL drop START outside IDLE, pulse CMD_DROP the following cycle, leave the current command unaffected.
REQ-018 SHALL in ISSUE assert SDRAM_READ with burst length min(BURST_MAX, remaining) only when outstanding + FIFO occupancy + burst <= FIFO_DEPTH.
REQ-019 SHALL hold ADDRESS/BURSTCOUNT/READ stable while WAITREQUEST=1; request accepted on READ&~WAITREQUEST.
REQ-020 SHALL on acceptance advance address by burst length, decrement remaining; go to DRAIN when remaining reaches 0.
REQ-021 SHALL write every READDATAVALID beat into the output FIFO in any state; never overflow (guaranteed by REQ-018).
REQ-022 SHALL leave DRAIN when all requested beats received, spend exactly one cycle in DONE incrementing DONE_CNT (wraps 65535->0).
REQ-023 SHALL present FIFO head on OUT_DATA, OUT_VALID = FIFO non-empty; first beat visible one cycle after its READDATAVALID.
REQ-024 SHALL support simultaneous FIFO write and read, occupancy unchanged.
REQ-025 SHALL keep BUSY=1 in ISSUE, DRAIN, DONE.
REQ-026 SHALL wrap address modulo 2^ADR_W without error.

Reset
REQ-027 SHALL on RST_N=0 force IDLE, SDRAM_READ=0, ADDRESS=0, BURSTCOUNT=0, BUSY=0, DONE_CNT=0, CMD_DROP=0, FIFO empty, OUT_VALID=0, outstanding=0.
REQ-028 SHALL on reset mid-burst discard late READDATAVALID beats arriving before the next START (outstanding counter cleared, beats dropped until IDLE accepts START).

Configuration
REQ-029 SHALL with DMA_RD_SWAP16_EN defined swap 16-bit halves within each 32-bit lane on OUT_DATA ({d[15:0],d[31:16]} per lane).
REQ-030 SHALL without DMA_RD_SWAP16_EN pass READDATA unmodified.

Structure
REQ-031 SHALL place FSM state enum, DONE_CNT width (16) and BURSTCOUNT width (8) in shared package dma_pkg.
REQ-032 SHALL implement the output FIFO as sub-module dma_rd_fifo (sync, show-ahead, DEPTH/WIDTH params, occupancy output).

Verification
REQ-033 SHALL test: START_ADR=0x100, BUF_SIZE=40, no waitrequest, OUT_READY=1 -> bursts 16@0x100, 16@0x110, 8@0x120; 40 beats out in order; DONE_CNT=1.
REQ-034 SHALL test: random WAITREQUEST 10-150 cycles -> ADDRESS/BURSTCOUNT stable during wait; no beat lost or duplicated.
REQ-035 SHALL test: OUT_READY=0, BUF_SIZE=200 -> reads stall at 64 beats total occupancy+outstanding; resume when READY=1.
REQ-036 SHALL test: START during ISSUE -> CMD_DROP pulses once; DONE_CNT increments once only.
REQ-037 SHALL test: BUF_SIZE=0 -> no SDRAM_READ, DONE_CNT+1 two cycles after START; DONE_CNT preset path 65535 -> 0.
REQ-038 SHALL test: RST_N low mid-DRAIN with 5 beats pending -> outputs at reset values; pending beats not emitted.
